// File: rtl/dmem_pkg.sv
// Shared types and helpers for the pipelined RV32 data memory.
// Load extension lives here so the final stage stays small.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10
  } size_e;

  typedef struct packed {
    logic       zext;
    logic [1:0] size;
  } dmem_ctrl_t;

  typedef struct packed {
    logic       valid;
    logic       write;
    size_e      size;
    logic       zext;
    logic [1:0] off;
    logic       err;
  } stage_t;

  function automatic logic [31:0] extend_load(
    input logic [31:0] word,
    input size_e       size,
    input logic        zext,
    input logic [1:0]  off
  );
    logic [31:0] sh;
    sh = word >> {off, 3'b000};
    case (size)
      SZ_B: extend_load = zext ? {24'h0, sh[7:0]}
                               : {{24{sh[7]}}, sh[7:0]};
      SZ_H: extend_load = zext ? {16'h0, sh[15:0]}
                               : {{16{sh[15]}}, sh[15:0]};
      default: extend_load = word;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Single-port word RAM with four byte lanes and a held read register.
// Storage is never reset.
module dmem_bank #(
  parameter int IDX_W = 15
) (
  input  logic             clk_i,
  input  logic             re,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  localparam int WORDS = 2 ** IDX_W;

  logic [3:0][7:0] mem [WORDS];

  always_ff @(posedge clk_i) begin
    for (int l = 0; l < 4; l++) begin
      if (we[l]) mem[idx][l] <= wdata[8*l +: 8];
    end
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_pipelined.sv
// RV32 data memory: valid/ready requests, in-order responses after
// LATENCY cycles, byte lanes, misalign/range fault reporting.
module dmem_pipelined
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH  = 17,
  parameter int LATENCY     = 2,
  parameter int CHECK_RANGE = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic [2:0]  req_ctrl_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  dmem_ctrl_t  ctrl;
  logic        stall;
  logic        accept;
  logic        misalign;
  logic        bad_range;
  logic        fault;
  logic [1:0]  off;
  logic [3:0]  be;
  logic [3:0]  we;
  logic [31:0] wlanes;
  logic [31:0] ram_q;
  logic [31:0] last_data;
  stage_t      nxt;
  stage_t      last;
  stage_t      stg [LATENCY];

  assign ctrl        = dmem_ctrl_t'(req_ctrl_i);
  assign off         = req_addr_i[1:0];
  assign stall       = rsp_valid_o & ~rsp_ready_i;
  assign req_ready_o = ~stall;
  assign accept      = req_valid_i & req_ready_o;

  if (CHECK_RANGE != 0) begin : g_range
    assign bad_range = |req_addr_i[31:ADDR_WIDTH];
  end else begin : g_norange
    assign bad_range = 1'b0;
  end

  always_comb begin
    misalign = 1'b0;
    be       = 4'b0000;
    wlanes   = req_wdata_i;
    unique case (1'b1)
      (ctrl.size == SZ_B): begin
        be     = 4'b0001 << off;
        wlanes = {4{req_wdata_i[7:0]}};
      end
      (ctrl.size == SZ_H): begin
        misalign = off[0];
        be       = 4'b0011 << off;
        wlanes   = {2{req_wdata_i[15:0]}};
      end
      (ctrl.size == SZ_W): begin
        misalign = |off;
        be       = 4'b1111;
      end
      default: misalign = 1'b1;
    endcase
  end

  assign fault = misalign | bad_range;
  assign we    = (accept & req_write_i & ~fault) ? be : 4'b0000;

  dmem_bank #(.IDX_W(IDX_W)) u_bank (
    .clk_i (clk_i),
    .re    (accept & ~req_write_i),
    .we    (we),
    .idx   (req_addr_i[ADDR_WIDTH-1:2]),
    .wdata (wlanes),
    .rdata (ram_q)
  );

  always_comb begin
    nxt = '0;
    if (accept) begin
      nxt.valid = 1'b1;
      nxt.write = req_write_i;
      nxt.size  = size_e'(ctrl.size);
      nxt.zext  = ctrl.zext;
      nxt.off   = off;
      nxt.err   = fault;
    end
  end

  // Whole pipe freezes on stall so bubbles never collapse under backpressure.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < LATENCY; i++) stg[i] <= '0;
    end else if (!stall) begin
      stg[0] <= nxt;
      for (int i = 1; i < LATENCY; i++) stg[i] <= stg[i-1];
    end
  end

  if (LATENCY == 1) begin : g_dnone
    assign last_data = ram_q;
  end else begin : g_dpipe
    logic [31:0] dq [LATENCY-1];
    always_ff @(posedge clk_i) begin
      if (!stall) begin
        dq[0] <= ram_q;
        for (int i = 1; i < LATENCY - 1; i++) dq[i] <= dq[i-1];
      end
    end
    assign last_data = dq[LATENCY-2];
  end

  assign last        = stg[LATENCY-1];
  assign rsp_valid_o = last.valid;
  assign rsp_err_o   = last.valid & last.err;
  assign rsp_rdata_o = (last.valid & ~last.write & ~last.err)
                     ? extend_load(last_data, last.size,
                                   last.zext, last.off)
                     : 32'h0;

endmodule

// File: tb/tb_dmem_pipelined.sv
// Directed bench for dmem_pipelined: stores, lane loads, faults,
// backpressure, range check and reset with requests in flight.
module tb_dmem_pipelined;

  localparam int LAT = 2;

  localparam logic [2:0] C_B   = 3'b000;
  localparam logic [2:0] C_H   = 3'b001;
  localparam logic [2:0] C_W   = 3'b010;
  localparam logic [2:0] C_BAD = 3'b011;
  localparam logic [2:0] C_BU  = 3'b100;
  localparam logic [2:0] C_HU  = 3'b101;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic [2:0]  req_ctrl = 3'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  dmem_pipelined #(
    .ADDR_WIDTH  (17),
    .LATENCY     (LAT),
    .CHECK_RANGE (1)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_write_i (req_write),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_ctrl_i  (req_ctrl),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_rdata_o (rsp_rdata),
    .rsp_err_o   (rsp_err)
  );

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [2:0]  c;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  function automatic vec_t mk(input logic w, input logic [31:0] a,
                              input logic [31:0] d, input logic [2:0] c,
                              input logic [31:0] er, input logic ee);
    mk = {w, a, d, c, er, ee};
  endfunction

  task automatic drive(input vec_t v);
    req_valid = 1'b1;
    req_write = v.w;
    req_addr  = v.a;
    req_wdata = v.d;
    req_ctrl  = v.c;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
        rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      failed++;
      $display("FAIL reset: valid=%b rdata=%h err=%b ready=%b want 0 0 0 1",
               rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_store_load();
    vec_t v [2];
    v[0] = mk(1'b1, 32'h100, 32'hDEADBEEF, C_W, 32'h0, 1'b0);
    v[1] = mk(1'b0, 32'h100, 32'h0, C_W, 32'hDEADBEEF, 1'b0);
    for (int k = 0; k < 2 + LAT; k++) begin
      @(negedge clk);
      tests++;
      if (k < LAT) begin
        if (rsp_valid !== 1'b0) begin
          failed++;
          $display("FAIL store_load_early[%0d]: valid=%b want 0", k, rsp_valid);
        end
      end else if (rsp_valid !== 1'b1 || rsp_rdata !== v[k-LAT].er ||
                   rsp_err !== v[k-LAT].ee) begin
        failed++;
        $display("FAIL store_load[%0d]: valid=%b rdata=%h err=%b want 1 %h %b",
                 k - LAT, rsp_valid, rsp_rdata, rsp_err,
                 v[k-LAT].er, v[k-LAT].ee);
      end
      if (k < 2) drive(v[k]);
      else idle();
    end
  endtask

  task automatic test_lanes();
    vec_t v [4];
    v[0] = mk(1'b0, 32'h103, 32'h0, C_B,  32'hFFFFFFDE, 1'b0);
    v[1] = mk(1'b0, 32'h103, 32'h0, C_BU, 32'h000000DE, 1'b0);
    v[2] = mk(1'b0, 32'h102, 32'h0, C_H,  32'hFFFFDEAD, 1'b0);
    v[3] = mk(1'b0, 32'h100, 32'h0, C_HU, 32'h0000BEEF, 1'b0);
    for (int k = 0; k < 4 + LAT; k++) begin
      @(negedge clk);
      tests++;
      if (k < LAT) begin
        if (rsp_valid !== 1'b0) begin
          failed++;
          $display("FAIL lanes_early[%0d]: valid=%b want 0", k, rsp_valid);
        end
      end else if (rsp_valid !== 1'b1 || rsp_rdata !== v[k-LAT].er ||
                   rsp_err !== v[k-LAT].ee) begin
        failed++;
        $display("FAIL lanes[%0d]: valid=%b rdata=%h err=%b want 1 %h %b",
                 k - LAT, rsp_valid, rsp_rdata, rsp_err,
                 v[k-LAT].er, v[k-LAT].ee);
      end
      if (k < 4) drive(v[k]);
      else idle();
    end
  endtask

  task automatic test_faults();
    vec_t v [4];
    v[0] = mk(1'b1, 32'h101, 32'h1234, C_H, 32'h0, 1'b1);
    v[1] = mk(1'b0, 32'h100, 32'h0, C_W, 32'hDEADBEEF, 1'b0);
    v[2] = mk(1'b0, 32'h102, 32'h0, C_W, 32'h0, 1'b1);
    v[3] = mk(1'b0, 32'h100, 32'h0, C_BAD, 32'h0, 1'b1);
    for (int k = 0; k < 4 + LAT; k++) begin
      @(negedge clk);
      tests++;
      if (k < LAT) begin
        if (rsp_valid !== 1'b0) begin
          failed++;
          $display("FAIL faults_early[%0d]: valid=%b want 0", k, rsp_valid);
        end
      end else if (rsp_valid !== 1'b1 || rsp_rdata !== v[k-LAT].er ||
                   rsp_err !== v[k-LAT].ee) begin
        failed++;
        $display("FAIL faults[%0d]: valid=%b rdata=%h err=%b want 1 %h %b",
                 k - LAT, rsp_valid, rsp_rdata, rsp_err,
                 v[k-LAT].er, v[k-LAT].ee);
      end
      if (k < 4) drive(v[k]);
      else idle();
    end
  endtask

  task automatic test_range();
    vec_t v [4];
    v[0] = mk(1'b1, 32'h0, 32'h11223344, C_W, 32'h0, 1'b0);
    v[1] = mk(1'b0, 32'h00020000, 32'h0, C_W, 32'h0, 1'b1);
    v[2] = mk(1'b1, 32'h00020000, 32'h55, C_B, 32'h0, 1'b1);
    v[3] = mk(1'b0, 32'h0, 32'h0, C_W, 32'h11223344, 1'b0);
    for (int k = 0; k < 4 + LAT; k++) begin
      @(negedge clk);
      tests++;
      if (k < LAT) begin
        if (rsp_valid !== 1'b0) begin
          failed++;
          $display("FAIL range_early[%0d]: valid=%b want 0", k, rsp_valid);
        end
      end else if (rsp_valid !== 1'b1 || rsp_rdata !== v[k-LAT].er ||
                   rsp_err !== v[k-LAT].ee) begin
        failed++;
        $display("FAIL range[%0d]: valid=%b rdata=%h err=%b want 1 %h %b",
                 k - LAT, rsp_valid, rsp_rdata, rsp_err,
                 v[k-LAT].er, v[k-LAT].ee);
      end
      if (k < 4) drive(v[k]);
      else idle();
    end
  endtask

  task automatic test_back_to_back();
    int          issued = 0;
    int          got    = 0;
    int          stalls = 0;
    logic        was_stall = 1'b0;
    logic        held_v = 1'b0;
    logic [31:0] held_d = 32'h0;
    logic        held_e = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      drive(mk(1'b1, 32'h200 + 32'(4 * i), 32'hC0DE0000 + 32'(i),
               C_W, 32'h0, 1'b0));
    end
    @(negedge clk);
    idle();
    repeat (LAT + 1) @(negedge clk);
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      rsp_ready = !(c >= 4 && c < 7);
      if (issued < 8)
        drive(mk(1'b0, 32'h200 + 32'(4 * issued), 32'h0, C_W, 32'h0, 1'b0));
      else
        idle();
      #1;
      if (was_stall) begin
        tests++;
        if (rsp_valid !== held_v || rsp_rdata !== held_d ||
            rsp_err !== held_e) begin
          failed++;
          $display("FAIL bp_hold[%0d]: valid=%b rdata=%h err=%b want %b %h %b",
                   c, rsp_valid, rsp_rdata, rsp_err, held_v, held_d, held_e);
        end
      end
      was_stall = 1'b0;
      tests++;
      if (rsp_valid === 1'b1 && !rsp_ready) begin
        stalls++;
        was_stall = 1'b1;
        held_v = rsp_valid;
        held_d = rsp_rdata;
        held_e = rsp_err;
        if (req_ready !== 1'b0) begin
          failed++;
          $display("FAIL bp_ready_stall[%0d]: ready=%b want 0", c, req_ready);
        end
      end else if (req_ready !== 1'b1) begin
        failed++;
        $display("FAIL bp_ready_free[%0d]: ready=%b want 1", c, req_ready);
      end
      if (rsp_valid === 1'b1 && rsp_ready) begin
        tests++;
        if (rsp_rdata !== 32'hC0DE0000 + 32'(got) || rsp_err !== 1'b0) begin
          failed++;
          $display("FAIL bp_order[%0d]: rdata=%h err=%b want %h 0",
                   got, rsp_rdata, rsp_err, 32'hC0DE0000 + 32'(got));
        end
        got++;
      end
      if (req_valid && req_ready === 1'b1) issued++;
    end
    @(negedge clk);
    idle();
    rsp_ready = 1'b1;
    tests++;
    if (got != 8) begin
      failed++;
      $display("FAIL bp_count: got %0d responses want 8", got);
    end
    tests++;
    if (stalls != 3) begin
      failed++;
      $display("FAIL bp_stalls: saw %0d stalled cycles want 3", stalls);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b0) begin
        failed++;
        $display("FAIL bp_extra[%0d]: valid=%b want 0", k, rsp_valid);
      end
    end
  endtask

  task automatic test_reset_inflight();
    @(negedge clk);
    drive(mk(1'b1, 32'h300, 32'hCAFEF00D, C_W, 32'h0, 1'b0));
    @(negedge clk);
    drive(mk(1'b0, 32'h300, 32'h0, C_W, 32'h0, 1'b0));
    @(negedge clk);
    drive(mk(1'b0, 32'h300, 32'h0, C_W, 32'h0, 1'b0));
    @(negedge clk);
    idle();
    rst = 1'b1;
    #1;
    tests++;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
        rsp_err !== 1'b0 || req_ready !== 1'b1) begin
      failed++;
      $display("FAIL rst_flight: valid=%b rdata=%h err=%b ready=%b want 0 0 0 1",
               rsp_valid, rsp_rdata, rsp_err, req_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests++;
      if (rsp_valid !== 1'b0) begin
        failed++;
        $display("FAIL rst_stale[%0d]: valid=%b want 0", k, rsp_valid);
      end
    end
    drive(mk(1'b0, 32'h300, 32'h0, C_W, 32'h0, 1'b0));
    @(negedge clk);
    idle();
    @(negedge clk);
    tests++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hCAFEF00D ||
        rsp_err !== 1'b0) begin
      failed++;
      $display("FAIL rst_keep: valid=%b rdata=%h err=%b want 1 cafef00d 0",
               rsp_valid, rsp_rdata, rsp_err);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_lanes();
    test_faults();
    test_range();
    test_back_to_back();
    test_reset_inflight();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
